// File: rtl/ray_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : ray_frame_gen
// Purpose  : Raster-order primary-ray generator with in-order result shading.
//            Issues one ray per pixel (origin at 0, direction from the pixel
//            coordinate) over a ready/valid handshake, then converts each
//            intersection result into a shaded pixel strobe. Signals the end
//            of the frame with a single-cycle frame_done pulse.
// Ports    : clock, reset (sync, active-high), start
//            ray_ready / ray_valid, ray_origin_x/y/z, ray_dir_x/y/z (Q8.8)
//            res_valid, res_hit, res_t (Q8.8)
//            pix_valid, pix_x, pix_y, pix_shade, busy, frame_done
// Macro    : RAY_FRAME_CONTINUOUS_EN - when defined, frames repeat
//            back-to-back without needing start, and busy stays high.
// Revision : 1.0 - initial release
// ============================================================================
module ray_frame_gen #(
  parameter int                 H_RES    = 16,
  parameter int                 V_RES    = 16,
  parameter logic signed [15:0] DIR_STEP = 16'sh0010,
  parameter logic        [7:0]  BG_SHADE = 8'h10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               ray_ready,
  output logic               ray_valid,
  output logic signed [15:0] ray_origin_x,
  output logic signed [15:0] ray_origin_y,
  output logic signed [15:0] ray_origin_z,
  output logic signed [15:0] ray_dir_x,
  output logic signed [15:0] ray_dir_y,
  output logic signed [15:0] ray_dir_z,
  input  logic               res_valid,
  input  logic               res_hit,
  input  logic signed [15:0] res_t,
  output logic               pix_valid,
  output logic        [7:0]  pix_x,
  output logic        [7:0]  pix_y,
  output logic        [7:0]  pix_shade,
  output logic               busy,
  output logic               frame_done
);

`ifdef RAY_FRAME_CONTINUOUS_EN
  localparam bit c_CONT = 1'b1;
`else
  localparam bit c_CONT = 1'b0;
`endif

  localparam logic [7:0] c_XLAST  = 8'(H_RES - 1);
  localparam logic [7:0] c_YLAST  = 8'(V_RES - 1);
  localparam int         c_HALF_H = H_RES / 2;
  localparam int         c_HALF_V = V_RES / 2;
  localparam int         c_STEP   = int'(DIR_STEP);
  localparam logic signed [15:0] c_DIR_Z = 16'shFF00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_ix, r_iy;   // coordinate of the ray currently presented
  logic [7:0] r_rx, r_ry;   // coordinate the next accepted result belongs to
  logic       r_res_all;    // every result of the frame has been accepted

  // Direction components; the product is truncated to 16 bits on purpose.
  function automatic logic [15:0] f_dir_x(input logic [7:0] x);
    return 16'((int'({24'd0, x}) - c_HALF_H) * c_STEP);
  endfunction

  function automatic logic [15:0] f_dir_y(input logic [7:0] y);
    return 16'((c_HALF_V - int'({24'd0, y})) * c_STEP);
  endfunction

  logic       w_xfer, w_ray_last, w_res_acc, w_res_last, w_res_done;
  logic       w_frame_start;
  logic [7:0] w_ix_inc, w_iy_inc;
  logic       w_t_pos;
  logic [15:0] w_t_shift;
  logic [7:0] w_dist, w_shade;

  assign w_xfer     = ray_valid && ray_ready;
  assign w_ray_last = (r_ix == c_XLAST) && (r_iy == c_YLAST);
  assign w_res_acc  = res_valid && !r_res_all &&
                      ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_res_last = w_res_acc && (r_rx == c_XLAST) && (r_ry == c_YLAST);
  assign w_res_done = w_res_last || r_res_all;

  // A new frame begins on start in IDLE, or straight out of DONE when
  // frames run back-to-back.
  assign w_frame_start = ((r_state == S_IDLE) && start) ||
                         ((r_state == S_DONE) && c_CONT);

  assign w_ix_inc = (r_ix == c_XLAST) ? 8'd0 : r_ix + 8'd1;
  assign w_iy_inc = (r_ix == c_XLAST) ? r_iy + 8'd1 : r_iy;

  // Shading: only a hit at positive distance is lit; distance/16 is
  // saturated to 255 and inverted so nearer hits are brighter.
  assign w_t_pos   = res_hit && (res_t > 16'sd0);
  assign w_t_shift = res_t >> 4;
  assign w_dist    = (|w_t_shift[15:8]) ? 8'hFF : w_t_shift[7:0];
  assign w_shade   = w_t_pos ? (8'hFF - w_dist) : BG_SHADE;

  assign ray_origin_x = 16'sd0;
  assign ray_origin_y = 16'sd0;
  assign ray_origin_z = 16'sd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ix       <= 8'd0;
      r_iy       <= 8'd0;
      r_rx       <= 8'd0;
      r_ry       <= 8'd0;
      r_res_all  <= 1'b0;
      ray_valid  <= 1'b0;
      ray_dir_x  <= 16'sd0;
      ray_dir_y  <= 16'sd0;
      ray_dir_z  <= 16'sd0;
      pix_valid  <= 1'b0;
      pix_x      <= 8'd0;
      pix_y      <= 8'd0;
      pix_shade  <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // ---------------- state machine and control outputs ----------------
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ISSUE;
            ray_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_xfer && w_ray_last) begin
            ray_valid <= 1'b0;
            if (w_res_done) begin
              r_state    <= S_DONE;
              busy       <= c_CONT;
              frame_done <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_res_done) begin
            r_state    <= S_DONE;
            busy       <= c_CONT;
            frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          if (c_CONT) begin
            r_state   <= S_ISSUE;
            ray_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // ---------------- counters and ray fields ----------------
      if (w_frame_start) begin
        r_ix      <= 8'd0;
        r_iy      <= 8'd0;
        r_rx      <= 8'd0;
        r_ry      <= 8'd0;
        r_res_all <= 1'b0;
        ray_dir_x <= f_dir_x(8'd0);
        ray_dir_y <= f_dir_y(8'd0);
        ray_dir_z <= c_DIR_Z;
      end else begin
        // Fields only move on a transfer, so they hold while stalled; after
        // the last ray they simply keep the final value.
        if (w_xfer && !w_ray_last) begin
          r_ix      <= w_ix_inc;
          r_iy      <= w_iy_inc;
          ray_dir_x <= f_dir_x(w_ix_inc);
          ray_dir_y <= f_dir_y(w_iy_inc);
        end
        if (w_res_acc) begin
          if (r_rx == c_XLAST) begin
            r_rx <= 8'd0;
            r_ry <= r_ry + 8'd1;
          end else begin
            r_rx <= r_rx + 8'd1;
          end
          if (w_res_last) begin
            r_res_all <= 1'b1;
          end
        end
      end

      // ---------------- pixel output ----------------
      pix_valid <= w_res_acc;
      if (w_res_acc) begin
        pix_x     <= r_rx;
        pix_y     <= r_ry;
        pix_shade <= w_shade;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ray_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_frame_gen
// Purpose  : Directed self-checking bench for ray_frame_gen with a 4x4 frame
//            and a direction step of 0.25 (Q8.8 0x0040).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_frame_gen;

  logic        clock = 1'b0;
  logic        reset, start, ray_ready;
  logic        ray_valid;
  logic [15:0] ray_origin_x, ray_origin_y, ray_origin_z;
  logic [15:0] ray_dir_x, ray_dir_y, ray_dir_z;
  logic        res_valid, res_hit;
  logic [15:0] res_t;
  logic        pix_valid;
  logic [7:0]  pix_x, pix_y, pix_shade;
  logic        busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  ray_frame_gen #(
    .H_RES   (4),
    .V_RES   (4),
    .DIR_STEP(16'sh0040),
    .BG_SHADE(8'h10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .ray_ready   (ray_ready),
    .ray_valid   (ray_valid),
    .ray_origin_x(ray_origin_x),
    .ray_origin_y(ray_origin_y),
    .ray_origin_z(ray_origin_z),
    .ray_dir_x   (ray_dir_x),
    .ray_dir_y   (ray_dir_y),
    .ray_dir_z   (ray_dir_z),
    .res_valid   (res_valid),
    .res_hit     (res_hit),
    .res_t       (res_t),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_shade   (pix_shade),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Expected direction for the n-th ray of a 4x4 frame, step 0x0040.
  function automatic logic [15:0] exp_dx(input int n);
    return 16'(((n % 4) - 2) * 64);
  endfunction
  function automatic logic [15:0] exp_dy(input int n);
    return 16'((2 - (n / 4)) * 64);
  endfunction

  // Reference shading.
  function automatic logic [7:0] exp_shade(input logic hit, input logic [15:0] t);
    int ts, d;
    ts = int'(signed'(t));
    if (!hit || ts <= 0) return 8'h10;
    d = ts / 16;
    if (d > 255) d = 255;
    return 8'(255 - d);
  endfunction

  logic        tab_hit [16];
  logic [15:0] tab_t   [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, stall, cyc;

    tab_hit = '{1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    tab_t   = '{16'h0200, 16'h1234, 16'h1000, 16'hFF00,
                16'h0000, 16'h0010, 16'h0FF0, 16'h7FFF,
                16'h0300, 16'h0001, 16'h8000, 16'h00F0,
                16'h0100, 16'h0A50, 16'h0020, 16'h0400};

    reset = 1'b1; start = 1'b0; ray_ready = 1'b0;
    res_valid = 1'b0; res_hit = 1'b0; res_t = 16'h0;
    tick(); tick();

    // ---- reset state ----
    chk("rst_ray_valid", ray_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_dir_x", ray_dir_x, 0);
    chk("rst_dir_z", ray_dir_z, 0);
    chk("rst_origin", {ray_origin_x, ray_origin_y}, 0);
    chk("rst_pix_shade", pix_shade, 0);
    reset = 1'b0;
    tick();

    // ---- full frame issue, always ready ----
    ray_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_dir_z", ray_dir_z, 16'hFF00);
    chk("first_busy", busy, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ray%0d_valid", k), ray_valid, 1);
      chk($sformatf("ray%0d_dx", k), ray_dir_x, exp_dx(k));
      chk($sformatf("ray%0d_dy", k), ray_dir_y, exp_dy(k));
      tick();
    end
    chk("after_issue_valid", ray_valid, 0);
    chk("after_issue_busy", busy, 1);

    // start while busy is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_valid", ray_valid, 0);
    chk("busy_start_busy", busy, 1);

    // ---- results with shading ----
    for (int i = 0; i < 16; i++) begin
      if (i == 6 || i == 10) begin
        res_valid = 1'b0;
        tick();
        chk($sformatf("gap%0d_pix_valid", i), pix_valid, 0);
      end
      res_valid = 1'b1; res_hit = tab_hit[i]; res_t = tab_t[i];
      tick();
      res_valid = 1'b0;
      chk($sformatf("res%0d_pix_valid", i), pix_valid, 1);
      chk($sformatf("res%0d_xy", i), {pix_x, pix_y}, {8'(i % 4), 8'(i / 4)});
      chk($sformatf("res%0d_shade", i), pix_shade, exp_shade(tab_hit[i], tab_t[i]));
      chk($sformatf("res%0d_frame_done", i), frame_done, (i == 15) ? 1 : 0);
      if (i == 15) start = 1'b1;   // start in DONE must be ignored
    end
    tick();
    start = 1'b0;
    chk("post_done_frame_done", frame_done, 0);
    chk("post_done_busy", busy, 0);
    chk("post_done_pix_valid", pix_valid, 0);
    chk("done_start_ignored", ray_valid, 0);
    tick();
    chk("idle_ray_valid", ray_valid, 0);

    // res_valid in IDLE is discarded
    res_valid = 1'b1; res_hit = 1'b1; res_t = 16'h0200;
    tick();
    res_valid = 1'b0;
    chk("idle_res_pix_valid", pix_valid, 0);

    // ---- stall at ray 5 for 3 cycles ----
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; stall = 0; cyc = 0;
    while (ray_valid && cyc < 40) begin
      if (n == 5 && stall < 3) begin
        ray_ready = 1'b0;
        stall++;
      end else begin
        ray_ready = 1'b1;
      end
      chk($sformatf("stall_c%0d_dx", cyc), ray_dir_x, exp_dx(n));
      chk($sformatf("stall_c%0d_dy", cyc), ray_dir_y, exp_dy(n));
      if (ray_ready) n++;
      cyc++;
      tick();
    end
    ray_ready = 1'b1;
    chk("stall_transfers", n, 16);
    chk("stall_cycles", cyc, 19);
    chk("stall_end_valid", ray_valid, 0);

    // a few results, then reset in DRAIN
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_hit = 1'b1; res_t = 16'h0100;
      tick();
      chk($sformatf("part%0d_x", i), pix_x, i);
    end
    res_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_pix_x", pix_x, 0);

    // ---- reset at ray 7 with results in flight ----
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      res_valid = 1'b1; res_hit = 1'b1; res_t = 16'h0010;
      tick();
      chk($sformatf("iss_res%0d_valid", k), pix_valid, 1);
      chk($sformatf("iss_res%0d_xy", k), {pix_x, pix_y}, {8'(k % 4), 8'(k / 4)});
      chk($sformatf("iss_res%0d_shade", k), pix_shade, 8'hFE);
    end
    chk("ray7_dx", ray_dir_x, exp_dx(7));
    chk("ray7_dy", ray_dir_y, exp_dy(7));
    reset = 1'b1;
    tick();
    reset = 1'b0; res_valid = 1'b0;
    chk("r7_ray_valid", ray_valid, 0);
    chk("r7_busy", busy, 0);
    chk("r7_pix_valid", pix_valid, 0);
    chk("r7_dir_x", ray_dir_x, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_valid", ray_valid, 1);
    chk("restart_dx", ray_dir_x, 16'hFF80);
    chk("restart_dy", ray_dir_y, 16'h0080);
    res_valid = 1'b1; res_hit = 1'b1; res_t = 16'h0200;
    tick();
    res_valid = 1'b0;
    chk("restart_pix_valid", pix_valid, 1);
    chk("restart_pix_xy", {pix_x, pix_y}, 0);
    chk("restart_shade", pix_shade, 8'hDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
